box_draw_engine: RTL and testbench

Parametrised rectangle rasteriser feeding the VGA adapter's pixel-write port. Latches a box origin, size, colour and draw mode on a start pulse, then emits one candidate pixel per cycle in raster order with plot/ready backpressure. Supports filled, outline and clear modes, and clips at the screen edge. Replaces the fixed-size box drawer behind the milestone top level; the top level keeps x/y capture from SW/KEY and drives this block's inputs.

---
 rtl/box_draw_pkg.sv | 9 +
 rtl/box_raster_counter.sv | 40 ++++
 rtl/box_draw_engine.sv | 89 ++++++++
 tb/tb_box_draw_engine.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/box_draw_pkg.sv
// box_draw_pkg: shared mode encodings, FSM state type and default screen size for the box rasteriser.
package box_draw_pkg;
    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_CLEAR   = 2'b10;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} state_t;
endpackage

// File: rtl/box_raster_counter.sv
// box_raster_counter: raster-order dx/dy nested counter with last and edge flags.
module box_raster_counter #(
    parameter int SIZE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [SIZE_W-1:0] w_i,
    input  logic [SIZE_W-1:0] h_i,
    output logic [SIZE_W-1:0] dx_o,
    output logic [SIZE_W-1:0] dy_o,
    output logic              last_o,
    output logic              x_edge_o,
    output logic              y_edge_o
);
    logic [SIZE_W-1:0] dx_q, dx_d, dy_q, dy_d, w_m1, h_m1;
    logic row_end;
    assign w_m1 = w_i - SIZE_W'(1);
    assign h_m1 = h_i - SIZE_W'(1);
    assign row_end = dx_q == w_m1;
    always_comb begin
        dx_d = clr_i ? '0 : adv_i ? (row_end ? '0 : dx_q + SIZE_W'(1)) : dx_q;
        dy_d = clr_i ? '0 : (adv_i && row_end) ? dy_q + SIZE_W'(1) : dy_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end
    assign dx_o     = dx_q;
    assign dy_o     = dy_q;
    assign last_o   = row_end && dy_q == h_m1;
    assign x_edge_o = dx_q == '0 || row_end;
    assign y_edge_o = dy_q == '0 || dy_q == h_m1;
endmodule

// File: rtl/box_draw_engine.sv
// box_draw_engine: rectangle rasteriser emitting one candidate pixel per cycle with plot/ready backpressure,
// fill/outline/clear modes and screen-edge clipping.
module box_draw_engine
    import box_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SIZE_W   = 4,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [SIZE_W-1:0]   width,
    input  logic [SIZE_W-1:0]   height,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [1:0]          mode,
    input  logic                plot_ready,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out
);
    state_t state_q, state_d;
    logic [X_W-1:0] x0_q;
    logic [Y_W-1:0] y0_q;
    logic [SIZE_W-1:0] w_q, h_q, dx, dy;
    logic [COLOUR_W-1:0] colour_q;
    logic [1:0] mode_q;
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    logic accept, in_draw, clipped, interior, adv, last, x_edge, y_edge;
    assign accept  = state_q == S_IDLE && start;
    assign in_draw = state_q == S_DRAW;
    // One extra bit so an origin near the top of the range clips rather than wraps.
    assign x_sum    = {1'b0, x0_q} + (X_W+1)'(dx);
    assign y_sum    = {1'b0, y0_q} + (Y_W+1)'(dy);
    assign clipped  = x_sum >= (X_W+1)'(SCREEN_W) || y_sum >= (Y_W+1)'(SCREEN_H);
    assign interior = mode_q == MODE_OUTLINE && !x_edge && !y_edge;
    assign adv      = in_draw && (!plot || plot_ready);
    box_raster_counter #(.SIZE_W(SIZE_W)) u_cnt (
        .clk(CLOCK_50), .rst(reset), .clr_i(accept), .adv_i(adv),
        .w_i(w_q), .h_i(h_q), .dx_o(dx), .dy_o(dy),
        .last_o(last), .x_edge_o(x_edge), .y_edge_o(y_edge)
    );
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
            mode_q   <= MODE_FILL;
        end else if (accept) begin
            x0_q     <= x0;
            y0_q     <= y0;
            w_q      <= width;
            h_q      <= height;
            colour_q <= colour;
            mode_q   <= mode;
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (width == '0 || height == '0) ? S_FINISH : S_DRAW;
            S_DRAW:   if (adv && last) state_d = S_FINISH;
            default:  state_d = S_IDLE;
        endcase
    end
    always_comb begin
        busy       = state_q != S_IDLE;
        done       = state_q == S_FINISH;
        plot       = in_draw && !clipped && !interior;
        x_out      = in_draw ? x_sum[X_W-1:0] : '0;
        y_out      = in_draw ? y_sum[Y_W-1:0] : '0;
        colour_out = (in_draw && mode_q != MODE_CLEAR) ? colour_q : '0;
    end
endmodule

// File: tb/tb_box_draw_engine.sv
// tb_box_draw_engine: directed checks of fill, outline, clip, backpressure, clear, zero-size and reset-abort.
module tb_box_draw_engine;
    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, plot_ready = 1'b1;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [3:0] width = '0, height = '0;
    logic [2:0] colour = '0;
    logic [1:0] mode = '0;
    logic busy, done, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    int total = 0, bad = 0;
    int px[$], py[$], pc[$];
    int lat, hits;

    always #10 clk = ~clk;

    box_draw_engine dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .x0(x0), .y0(y0),
        .width(width), .height(height), .colour(colour), .mode(mode),
        .plot_ready(plot_ready), .busy(busy), .done(done), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one box with plot_ready held high; lat is cycles from start edge to done.
    task automatic run_box(input int bx, input int by, input int bw, input int bh,
                           input int bc, input int bm, output int l);
        px.delete(); py.delete(); pc.delete();
        l = -1;
        x0 = 8'(bx); y0 = 7'(by); width = 4'(bw); height = 4'(bh);
        colour = 3'(bc); mode = 2'(bm); plot_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                l = c;
                break;
            end
            if (plot && plot_ready) begin
                px.push_back(int'(x_out)); py.push_back(int'(y_out)); pc.push_back(int'(colour_out));
            end
            step();
        end
        step();
        chk("busy_low_after_done", int'(busy), 0);
    endtask

    initial begin
        step(); step();
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_colour", int'(colour_out), 0);

        run_box(72, 8, 4, 4, 5, 0, lat);
        chk("fill_latency", lat, 17);
        chk("fill_count", px.size(), 16);
        for (int i = 0; i < 16 && i < px.size(); i++) begin
            chk("fill_x", px[i], 72 + i % 4);
            chk("fill_y", py[i], 8 + i / 4);
            chk("fill_colour", pc[i], 5);
        end

        run_box(72, 8, 4, 4, 5, 1, lat);
        chk("outline_latency", lat, 17);
        chk("outline_count", px.size(), 12);
        hits = 0;
        foreach (px[i]) if (px[i] inside {[73:74]} && py[i] inside {[9:10]}) hits++;
        chk("outline_interior_hits", hits, 0);
        if (px.size() == 12) begin
            chk("outline_x4", px[4], 72);
            chk("outline_x5", px[5], 75);
            chk("outline_y5", py[5], 9);
            chk("outline_x11", px[11], 75);
        end

        run_box(158, 118, 4, 4, 2, 0, lat);
        chk("clip_latency", lat, 17);
        chk("clip_count", px.size(), 4);
        if (px.size() == 4) begin
            chk("clip_p0", px[0] * 1000 + py[0], 158118);
            chk("clip_p1", px[1] * 1000 + py[1], 159118);
            chk("clip_p2", px[2] * 1000 + py[2], 158119);
            chk("clip_p3", px[3] * 1000 + py[3], 159119);
        end

        // Backpressure: 2x2 at (10,20); ready low for cycles 2..4 while pixel 2 is presented.
        x0 = 8'd10; y0 = 7'd20; width = 4'd2; height = 4'd2; colour = 3'd3; mode = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        hits = 0;
        for (int c = 1; c <= 8; c++) begin
            plot_ready = !(c >= 2 && c <= 4);
            if (c == 1) begin
                chk("bp_busy_first", int'(busy), 1);
                chk("bp_x_first", int'(x_out), 10);
            end
            if (c >= 2 && c <= 4) begin
                chk("bp_stall_plot", int'(plot), 1);
                chk("bp_stall_x", int'(x_out), 11);
                chk("bp_stall_y", int'(y_out), 20);
            end
            if (c == 7) chk("bp_done_early", int'(done), 0);
            if (c == 8) chk("bp_done", int'(done), 1);
            if (plot && plot_ready) hits++;
            step();
        end
        plot_ready = 1'b1;
        chk("bp_count", hits, 4);

        run_box(0, 0, 3, 2, 7, 2, lat);
        chk("clear_latency", lat, 7);
        chk("clear_count", px.size(), 6);
        hits = 0;
        foreach (pc[i]) if (pc[i] != 0) hits++;
        chk("clear_colour_nonzero", hits, 0);

        run_box(5, 5, 0, 3, 1, 0, lat);
        chk("zero_latency", lat, 1);
        chk("zero_count", px.size(), 0);

        // Reset mid-box, with a start pulse during busy that must not restart the box.
        x0 = 8'd72; y0 = 7'd8; width = 4'd4; height = 4'd4; colour = 3'd5; mode = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        x0 = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("midbox_x3", int'(x_out), 74);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_plot", int'(plot), 0);
        chk("abort_x", int'(x_out), 0);
        chk("abort_colour", int'(colour_out), 0);
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) hits++;
            step();
        end
        chk("abort_no_done", hits, 0);

        run_box(3, 4, 1, 1, 6, 3, lat);
        chk("after_abort_latency", lat, 2);
        chk("after_abort_count", px.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
